// File: rtl/store_buffer.sv
// store_buffer: small store FIFO in front of data_memory with
// store-to-load forwarding. Loads own the memory port when present;
// otherwise the oldest buffered store drains one entry per cycle.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_req,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_fwd,
  input  logic                     flush,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_writedata,
  output logic                     mem_memread,
  output logic                     mem_memwrite,
  input  logic [DATA_W-1:0]        mem_readdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             buf_q [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   fwd_idx;

  assign st_ready = (count_q != CNT_W'(DEPTH)) && !flush;
  assign push     = st_valid && st_ready;
  assign pop      = mem_memwrite;
  assign count    = count_q;
  assign empty    = (count_q == '0);

  // Memory port arbitration: a pending load always wins over draining.
  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;
    if (ld_req) begin
      mem_address = ld_addr;
      mem_memread = 1'b1;
    end else if (count_q != '0) begin
      mem_address   = buf_q[head_q].addr;
      mem_writedata = buf_q[head_q].data;
      mem_memwrite  = 1'b1;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    ld_data = mem_readdata;
    ld_fwd  = 1'b0;
    fwd_idx = '0;
    if (ld_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (buf_q[fwd_idx].addr == ld_addr)) begin
          ld_data = buf_q[fwd_idx].data;
          ld_fwd  = 1'b1;
        end
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      if (push) begin
        buf_q[tail_q] <= '{addr: st_addr, data: st_data};
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a data_memory model (word i resets to i),
// a vector table replayed through a scoreboard queue, and a hand-written
// asynchronous-reset-mid-drain sequence.
module tb_store_buffer;

  logic       CLK;
  logic       RESET;
  logic       st_valid;
  logic [7:0] st_addr;
  logic [7:0] st_data;
  logic       st_ready;
  logic       ld_req;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_fwd;
  logic       flush;
  logic       empty;
  logic [2:0] count;
  logic [7:0] mem_address;
  logic [7:0] mem_writedata;
  logic       mem_memread;
  logic       mem_memwrite;
  logic [7:0] mem_readdata;

  int n_chk;
  int n_fail;

  store_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_ready     (st_ready),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_fwd       (ld_fwd),
    .flush        (flush),
    .empty        (empty),
    .count        (count),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_readdata (mem_readdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // data_memory model: resets word i to i, writes on rising edge.
  logic [7:0] dmem [256];
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'(i);
    end else if (mem_memwrite) begin
      dmem[mem_address] <= mem_writedata;
    end
  end
  assign mem_readdata = dmem[mem_address];

  typedef struct {
    logic       stv;
    logic [7:0] sta;
    logic [7:0] std;
    logic       ldr;
    logic [7:0] lda;
    logic       fl;
    logic       e_rdy;
    logic [2:0] e_cnt;
    logic       e_empty;
    logic [7:0] e_ldd;
    logic       e_fwd;
    logic       e_mw;
    logic       e_mr;
    logic [7:0] e_ma;
    logic [7:0] e_wd;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_req = 1'b0; ld_addr = '0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vec_t e;
    n_chk = 0;
    n_fail = 0;
    idle();
    RESET = 1'b0;

    // stv sta std ldr lda fl | rdy cnt empty ldd fwd mw mr ma wd
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h05,1'b0, 1'b1,3'd0,1'b1,8'h05,1'b0,1'b0,1'b1,8'h05,8'h00});
    vecs.push_back('{1'b1,8'h03,8'hAA,1'b1,8'h03,1'b0, 1'b1,3'd0,1'b1,8'h03,1'b0,1'b0,1'b1,8'h03,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h03,1'b0, 1'b1,3'd1,1'b0,8'hAA,1'b1,1'b0,1'b1,8'h03,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b1,3'd1,1'b0,8'h03,1'b0,1'b1,1'b0,8'h03,8'hAA});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h03,1'b0, 1'b1,3'd0,1'b1,8'hAA,1'b0,1'b0,1'b1,8'h03,8'h00});
    vecs.push_back('{1'b1,8'h07,8'h11,1'b1,8'h07,1'b0, 1'b1,3'd0,1'b1,8'h07,1'b0,1'b0,1'b1,8'h07,8'h00});
    vecs.push_back('{1'b1,8'h07,8'h22,1'b1,8'h07,1'b0, 1'b1,3'd1,1'b0,8'h11,1'b1,1'b0,1'b1,8'h07,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h07,1'b0, 1'b1,3'd2,1'b0,8'h22,1'b1,1'b0,1'b1,8'h07,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b1,3'd2,1'b0,8'h07,1'b0,1'b1,1'b0,8'h07,8'h11});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b1,3'd1,1'b0,8'h11,1'b0,1'b1,1'b0,8'h07,8'h22});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h07,1'b0, 1'b1,3'd0,1'b1,8'h22,1'b0,1'b0,1'b1,8'h07,8'h00});
    for (int k = 0; k < 4; k++) begin
      vecs.push_back('{1'b1,8'(8'h10+k),8'(8'hA0+k),1'b1,8'h20,1'b0,
                       1'b1,3'(k),(k==0),8'h20,1'b0,1'b0,1'b1,8'h20,8'h00});
    end
    vecs.push_back('{1'b1,8'h14,8'hB4,1'b1,8'h20,1'b0, 1'b0,3'd4,1'b0,8'h20,1'b0,1'b0,1'b1,8'h20,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h14,1'b0, 1'b0,3'd4,1'b0,8'h14,1'b0,1'b0,1'b1,8'h14,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h12,1'b0, 1'b0,3'd4,1'b0,8'hA2,1'b1,1'b0,1'b1,8'h12,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b0,3'd4,1'b0,8'h10,1'b0,1'b1,1'b0,8'h10,8'hA0});
    vecs.push_back('{1'b1,8'h15,8'hB5,1'b0,8'h00,1'b0, 1'b1,3'd3,1'b0,8'h11,1'b0,1'b1,1'b0,8'h11,8'hA1});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h15,1'b0, 1'b1,3'd3,1'b0,8'hB5,1'b1,1'b0,1'b1,8'h15,8'h00});
    vecs.push_back('{1'b1,8'h30,8'hC0,1'b0,8'h00,1'b1, 1'b0,3'd3,1'b0,8'h12,1'b0,1'b1,1'b0,8'h12,8'hA2});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,3'd2,1'b0,8'h13,1'b0,1'b1,1'b0,8'h13,8'hA3});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,3'd1,1'b0,8'h15,1'b0,1'b1,1'b0,8'h15,8'hB5});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,3'd0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h30,1'b0, 1'b1,3'd0,1'b1,8'h30,1'b0,1'b0,1'b1,8'h30,8'h00});
    vecs.push_back('{1'b0,8'h00,8'h00,1'b1,8'h13,1'b0, 1'b1,3'd0,1'b1,8'hA3,1'b0,1'b0,1'b1,8'h13,8'h00});

    // Outputs while reset is held.
    #3;
    chk("rst.st_ready", 32'(st_ready), 32'd1);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst.memread", 32'(mem_memread), 32'd0);
    chk("rst.ld_fwd", 32'(ld_fwd), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK);
      #1;
      v = vecs[i];
      st_valid = v.stv; st_addr = v.sta; st_data = v.std;
      ld_req = v.ldr; ld_addr = v.lda; flush = v.fl;
      sb.push_back(v);
      @(negedge CLK);
      e = sb.pop_front();
      chk($sformatf("v%0d.st_ready", i), 32'(st_ready), 32'(e.e_rdy));
      chk($sformatf("v%0d.count", i), 32'(count), 32'(e.e_cnt));
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(e.e_empty));
      chk($sformatf("v%0d.ld_data", i), 32'(ld_data), 32'(e.e_ldd));
      chk($sformatf("v%0d.ld_fwd", i), 32'(ld_fwd), 32'(e.e_fwd));
      chk($sformatf("v%0d.memwrite", i), 32'(mem_memwrite), 32'(e.e_mw));
      chk($sformatf("v%0d.memread", i), 32'(mem_memread), 32'(e.e_mr));
      chk($sformatf("v%0d.mem_address", i), 32'(mem_address), 32'(e.e_ma));
      if (e.e_mw) chk($sformatf("v%0d.writedata", i), 32'(mem_writedata), 32'(e.e_wd));
    end

    // Asynchronous reset in the middle of draining two stores.
    @(posedge CLK); #1;
    idle(); st_valid = 1'b1; st_addr = 8'h40; st_data = 8'hD0; ld_req = 1'b1; ld_addr = 8'h50;
    @(posedge CLK); #1;
    st_addr = 8'h41; st_data = 8'hD1;
    @(posedge CLK); #1;
    idle();
    @(negedge CLK);
    chk("ar.count_before", 32'(count), 32'd2);
    chk("ar.memwrite_before", 32'(mem_memwrite), 32'd1);
    @(posedge CLK); #2;
    chk("ar.memwrite_mid", 32'(mem_memwrite), 32'd1);
    chk("ar.addr_mid", 32'(mem_address), 32'h41);
    RESET = 1'b0;
    #1;
    chk("ar.memwrite", 32'(mem_memwrite), 32'd0);
    chk("ar.count", 32'(count), 32'd0);
    chk("ar.empty", 32'(empty), 32'd1);
    chk("ar.st_ready", 32'(st_ready), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    ld_req = 1'b1; ld_addr = 8'h40;
    @(negedge CLK);
    chk("ar.ld40_data", 32'(ld_data), 32'h40);
    chk("ar.ld40_fwd", 32'(ld_fwd), 32'd0);
    @(posedge CLK); #1;
    ld_addr = 8'h41;
    @(negedge CLK);
    chk("ar.ld41_data", 32'(ld_data), 32'h41);
    chk("ar.ld41_fwd", 32'(ld_fwd), 32'd0);
    chk("ar.sb_empty", 32'(sb.size()), 32'd0);
    @(posedge CLK); #1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
